// File: rtl/proc_bus_pkg.sv
// Shared types and bus constants for the processor memory responder.
package proc_bus_pkg;

  localparam int DW = 9;
  localparam int AW = 9;
  localparam int RAM_DEPTH = 128;
  localparam int RD_LAT = 1;
  localparam logic [AW-1:0] LED_ADDR = 9'h080;
  localparam logic [AW-1:0] SW_ADDR = 9'h100;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_RESP,
    WR
  } resp_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_NONE
  } region_t;

endpackage

// File: rtl/sync_ram_1p.sv
// Single-port RAM: synchronous write, registered read.
// Not reset; contents persist across resetn.
module sync_ram_1p #(
  parameter int DEPTH = 128,
  parameter int DW = 9
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Memory-side responder: address latch, decode, read/write FSM.
// Reads return after RD_LAT clocks; writes commit in one.
module proc_mem_responder
  import proc_bus_pkg::*;
#(
  parameter int DW = proc_bus_pkg::DW,
  parameter int AW = proc_bus_pkg::AW,
  parameter int RAM_DEPTH = proc_bus_pkg::RAM_DEPTH,
  parameter logic [AW-1:0] LED_ADDR = proc_bus_pkg::LED_ADDR,
  parameter logic [AW-1:0] SW_ADDR = proc_bus_pkg::SW_ADDR,
  parameter int RD_LAT = proc_bus_pkg::RD_LAT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] addr,
  input  logic          addr_vld,
  input  logic [DW-1:0] wdata,
  input  logic          w_d,
  input  logic [DW-1:0] sw,
  output logic [DW-1:0] din,
  output logic          rd_valid,
  output logic          wr_done,
  output logic [DW-1:0] ledr,
  output logic          err
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [1:0] CNT_INIT =
    2'((RD_LAT > 1) ? RD_LAT - 2 : 0);
  localparam resp_state_t RD_FIRST =
    (RD_LAT > 1) ? RD_WAIT : RD_RESP;

  function automatic region_t decode(
    input logic [AW-1:0] a
  );
    if (int'(a) < RAM_DEPTH) return REG_RAM;
    if (a == LED_ADDR) return REG_LED;
    if (a == SW_ADDR) return REG_SW;
    return REG_NONE;
  endfunction

  resp_state_t   r_state;
  logic [AW-1:0] r_addr_q;
  logic [AW-1:0] r_pend_addr;
  logic [DW-1:0] r_pend_data;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_ledr;
  logic [1:0]    r_cnt;
  logic          r_pend;
  logic          r_rd_req;
  logic          r_err;

  logic [AW-1:0]     w_eff_addr;
  logic [AW-1:0]     w_wr_addr;
  logic [DW-1:0]     w_wr_data;
  logic [DW-1:0]     w_rd_data;
  logic [DW-1:0]     w_ram_q;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_can_start;
  logic              w_do_wr;
  logic              w_rd_start;
  logic              w_rd_any;
  logic              w_ram_we;
  region_t           w_wr_reg;
  region_t           w_rd_reg;
  region_t           w_start_reg;

  assign w_eff_addr = addr_vld ? addr : r_addr_q;
  assign w_can_start = (r_state == IDLE) ||
    (r_state == WR) ||
    (r_state == RD_RESP && !r_pend);

  // A held write wins the port in RD_RESP; else w_d starts one.
  always_comb begin
    w_do_wr = 1'b0;
    w_wr_addr = w_eff_addr;
    w_wr_data = wdata;
    if (r_state == RD_RESP && r_pend) begin
      w_do_wr = 1'b1;
      w_wr_addr = r_pend_addr;
      w_wr_data = r_pend_data;
    end else if (w_can_start && w_d) begin
      w_do_wr = 1'b1;
    end
  end

  assign w_rd_start = w_can_start && !w_d &&
    (addr_vld || r_rd_req);
  assign w_rd_any = w_rd_start ||
    (r_state == RD_WAIT && addr_vld);

  assign w_wr_reg = decode(w_wr_addr);
  assign w_rd_reg = decode(r_addr_q);
  assign w_start_reg = decode(w_eff_addr);

  assign w_ram_we = w_do_wr && resetn &&
    (w_wr_reg == REG_RAM);
  assign w_ram_addr = w_do_wr ?
    w_wr_addr[RAM_AW-1:0] : w_eff_addr[RAM_AW-1:0];

  sync_ram_1p #(
    .DEPTH(RAM_DEPTH),
    .DW   (DW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_wr_data),
    .o_rdata(w_ram_q)
  );

  always_comb begin
    w_rd_data = '0;
    unique case (w_rd_reg)
      REG_RAM: w_rd_data = w_ram_q;
      REG_LED: w_rd_data = r_ledr;
      REG_SW:  w_rd_data = sw;
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_addr_q <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_din <= '0;
      r_ledr <= '0;
      r_cnt <= '0;
      r_pend <= 1'b0;
      r_rd_req <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (addr_vld) r_addr_q <= addr;
      if (r_state == RD_RESP) r_din <= w_rd_data;
      if (w_do_wr) begin
        if (w_wr_reg == REG_LED) r_ledr <= w_wr_data;
        if (w_wr_reg == REG_SW || w_wr_reg == REG_NONE)
          r_err <= 1'b1;
      end
      if (w_rd_any && w_start_reg == REG_NONE)
        r_err <= 1'b1;
      unique case (r_state)
        RD_WAIT: begin
          if (w_d) begin
            r_pend <= 1'b1;
            r_pend_addr <= w_eff_addr;
            r_pend_data <= wdata;
            if (r_pend) r_err <= 1'b1;
          end
          if (addr_vld) r_cnt <= CNT_INIT;
          else if (r_cnt == '0) r_state <= RD_RESP;
          else r_cnt <= r_cnt - 2'd1;
        end
        RD_RESP: begin
          if (r_pend) begin
            r_pend <= 1'b0;
            r_state <= WR;
            r_rd_req <= addr_vld;
            if (w_d) r_err <= 1'b1;
          end else if (w_d) begin
            r_state <= WR;
          end else if (w_rd_start) begin
            r_state <= RD_FIRST;
            r_cnt <= CNT_INIT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          if (w_d) begin
            r_state <= WR;
          end else if (w_rd_start) begin
            r_state <= RD_FIRST;
            r_cnt <= CNT_INIT;
            r_rd_req <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign din = (r_state == RD_RESP) ? w_rd_data : r_din;
  assign rd_valid = (r_state == RD_RESP);
  assign wr_done = (r_state == WR);
  assign ledr = r_ledr;
  assign err = r_err;

endmodule
